// File: rtl/exc_ctrl.sv
// Exception/interrupt sequencer beside WB: picks the winning cause, commits it to CP0,
// redirects the PC and holds cancel until the wrong-path instructions have drained.
module exc_ctrl #(
  parameter logic [31:0] EXC_ENTER_ADDR = 32'hBFC00380,
  parameter int unsigned FLUSH_CYCLES   = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        wb_valid,
  input  logic [31:0] wb_pc,
  input  logic [31:0] dm_addr,
  input  logic [6:0]  exc_vec,
  input  logic        eret,
  input  logic [31:0] epc,
  input  logic        status_ie,
  input  logic        status_exl,
  input  logic [5:0]  int_mask,
  input  logic [5:0]  hw_int,
  output logic        wb_kill,
  output logic        exc_commit,
  output logic        eret_commit,
  output logic [4:0]  exc_code,
  output logic [31:0] epc_out,
  output logic        badvaddr_wen,
  output logic [31:0] badvaddr,
  output logic [5:0]  ip_pending,
  output logic [32:0] exc_bus,
  output logic        cancel,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, REDIRECT, FLUSH} state_e;

  state_e      state_q, state_d;
  logic [3:0]  flushCnt_q, flushCnt_d;
  logic [5:0]  ipSync_q, ipPending_q;
  logic        isEret_q;
  logic [4:0]  excCode_q;
  logic [31:0] epcOut_q;
  logic        badWen_q;
  logic [31:0] badAddr_q;

  logic        intReq, anyExc, evt, load;
  logic [4:0]  causeCode;
  logic        causeBadWen;
  logic [31:0] causeBadAddr;

  // Fixed-priority cause encoder; an eret alone falls through with code 0 and no BadVAddr.
  always_comb begin
    intReq       = (|(ipPending_q & int_mask)) & status_ie & ~status_exl;
    anyExc       = |exc_vec;
    evt          = wb_valid & (intReq | anyExc | eret);
    causeCode    = 5'd0;
    causeBadWen  = 1'b0;
    causeBadAddr = 32'd0;
    if (intReq) begin
      causeCode = 5'd0;
    end else if (exc_vec[6]) begin
      causeCode    = 5'd4;
      causeBadWen  = 1'b1;
      causeBadAddr = wb_pc;
    end else if (exc_vec[5]) begin
      causeCode = 5'd10;
    end else if (exc_vec[4]) begin
      causeCode = 5'd12;
    end else if (exc_vec[3]) begin
      causeCode = 5'd8;
    end else if (exc_vec[2]) begin
      causeCode = 5'd9;
    end else if (exc_vec[1]) begin
      causeCode    = 5'd4;
      causeBadWen  = 1'b1;
      causeBadAddr = dm_addr;
    end else if (exc_vec[0]) begin
      causeCode    = 5'd5;
      causeBadWen  = 1'b1;
      causeBadAddr = dm_addr;
    end
  end

  always_comb begin
    state_d    = state_q;
    flushCnt_d = flushCnt_q;
    load       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (evt) begin
          state_d = REDIRECT;
          load    = 1'b1;
        end
      end
      REDIRECT: begin
        state_d    = FLUSH;
        flushCnt_d = 4'(FLUSH_CYCLES - 1);
      end
      FLUSH: begin
        if (flushCnt_q == 4'd0) state_d = IDLE;
        else                    flushCnt_d = flushCnt_q - 4'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      flushCnt_q  <= 4'd0;
      ipSync_q    <= 6'd0;
      ipPending_q <= 6'd0;
      isEret_q    <= 1'b0;
      excCode_q   <= 5'd0;
      epcOut_q    <= 32'd0;
      badWen_q    <= 1'b0;
      badAddr_q   <= 32'd0;
    end else begin
      state_q     <= state_d;
      flushCnt_q  <= flushCnt_d;
      ipSync_q    <= hw_int;
      ipPending_q <= ipSync_q;
      if (load) begin
        isEret_q  <= eret & ~(intReq | anyExc);
        excCode_q <= causeCode;
        epcOut_q  <= wb_pc;
        badWen_q  <= causeBadWen;
        badAddr_q <= causeBadAddr;
      end
    end
  end

  // resetn gates wb_kill so it reads 0 while reset is held, like every other output.
  assign wb_kill      = resetn & (state_q == IDLE) & wb_valid & (intReq | anyExc);
  assign exc_commit   = (state_q == REDIRECT) & ~isEret_q;
  assign eret_commit  = (state_q == REDIRECT) & isEret_q;
  assign exc_bus      = (state_q != REDIRECT) ? 33'd0 :
                        (isEret_q ? {1'b1, epc} : {1'b1, EXC_ENTER_ADDR});
  assign cancel       = (state_q != IDLE);
  assign busy         = (state_q != IDLE);
  assign exc_code     = excCode_q;
  assign epc_out      = epcOut_q;
  assign badvaddr_wen = badWen_q;
  assign badvaddr     = badAddr_q;
  assign ip_pending   = ipPending_q;

endmodule

// File: tb/tb_exc_ctrl.sv
// Directed bench for exc_ctrl: a table of single-cause/priority vectors plus
// hand-written interrupt, flush-ignore and mid-sequence reset sequences.
module tb_exc_ctrl;

  localparam logic [31:0] ENTRY = 32'hBFC00380;

  logic        clk = 1'b0;
  logic        resetn;
  logic        wb_valid;
  logic [31:0] wb_pc, dm_addr, epc;
  logic [6:0]  exc_vec;
  logic        eret, status_ie, status_exl;
  logic [5:0]  int_mask, hw_int;
  logic        wb_kill, exc_commit, eret_commit, badvaddr_wen, cancel, busy;
  logic [4:0]  exc_code;
  logic [31:0] epc_out, badvaddr;
  logic [5:0]  ip_pending;
  logic [32:0] exc_bus;

  int passCnt  = 0;
  int totalCnt = 0;

  exc_ctrl #(.EXC_ENTER_ADDR(ENTRY), .FLUSH_CYCLES(2)) dut (
    .clk(clk), .resetn(resetn), .wb_valid(wb_valid), .wb_pc(wb_pc),
    .dm_addr(dm_addr), .exc_vec(exc_vec), .eret(eret), .epc(epc),
    .status_ie(status_ie), .status_exl(status_exl), .int_mask(int_mask),
    .hw_int(hw_int), .wb_kill(wb_kill), .exc_commit(exc_commit),
    .eret_commit(eret_commit), .exc_code(exc_code), .epc_out(epc_out),
    .badvaddr_wen(badvaddr_wen), .badvaddr(badvaddr), .ip_pending(ip_pending),
    .exc_bus(exc_bus), .cancel(cancel), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]  vec;
    logic        er;
    logic [31:0] pc;
    logic [31:0] addr;
    logic [31:0] ep;
    logic        kill;
    logic        isEret;
    logic [4:0]  code;
    logic        bwen;
    logic [31:0] bva;
  } vec_t;

  localparam int NV = 10;
  vec_t vecs[NV];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    totalCnt++;
    if (act === exp) passCnt++;
    else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clearInputs;
    wb_valid = 1'b0;
    exc_vec  = 7'd0;
    eret     = 1'b0;
  endtask

  task automatic applyStimulus(input vec_t v);
    wb_valid = 1'b1;
    exc_vec  = v.vec;
    eret     = v.er;
    wb_pc    = v.pc;
    dm_addr  = v.addr;
    epc      = v.ep;
  endtask

  task automatic waitIdle(input string name);
    for (int k = 0; k < 20 && busy; k++) tick;
    checkOutput(name, busy, 1'b0);
  endtask

  initial begin
    int cancelCnt, validCnt;
    // vec bits: {fetch, rsvd, ovf, sys, brk, raddr, waddr}
    vecs[0] = '{7'b0010000, 1'b0, 32'h80000010, 32'h0,    32'h0,        1, 0, 5'd12, 0, 32'h0};
    vecs[1] = '{7'b0001010, 1'b1, 32'h80000014, 32'h1003, 32'h80000400, 1, 0, 5'd8,  0, 32'h0};
    vecs[2] = '{7'b0000010, 1'b0, 32'h80000018, 32'h1003, 32'h0,        1, 0, 5'd4,  1, 32'h1003};
    vecs[3] = '{7'b0000000, 1'b1, 32'h8000001C, 32'h0,    32'h80000400, 0, 1, 5'd0,  0, 32'h0};
    vecs[4] = '{7'b1000000, 1'b0, 32'h80000020, 32'h5555, 32'h0,        1, 0, 5'd4,  1, 32'h80000020};
    vecs[5] = '{7'b1000001, 1'b0, 32'h80000024, 32'h6666, 32'h0,        1, 0, 5'd4,  1, 32'h80000024};
    vecs[6] = '{7'b0100000, 1'b0, 32'h80000028, 32'h0,    32'h0,        1, 0, 5'd10, 0, 32'h0};
    vecs[7] = '{7'b0000101, 1'b0, 32'h8000002C, 32'h7777, 32'h0,        1, 0, 5'd9,  0, 32'h0};
    vecs[8] = '{7'b0000001, 1'b0, 32'h80000030, 32'h2002, 32'h0,        1, 0, 5'd5,  1, 32'h2002};
    vecs[9] = '{7'b0011000, 1'b0, 32'h80000034, 32'h0,    32'h0,        1, 0, 5'd12, 0, 32'h0};

    // Reset held with active inputs: everything must read 0.
    resetn = 1'b0; status_ie = 1'b1; status_exl = 1'b0; int_mask = 6'h3F; hw_int = 6'h3F;
    wb_valid = 1'b1; exc_vec = 7'b0010000; eret = 1'b0;
    wb_pc = 32'h80000010; dm_addr = 32'h0; epc = 32'h0;
    tick; tick; tick;
    checkOutput("rst wb_kill", wb_kill, 0);
    checkOutput("rst busy", busy, 0);
    checkOutput("rst cancel", cancel, 0);
    checkOutput("rst exc_bus", exc_bus, 0);
    checkOutput("rst ip_pending", ip_pending, 0);
    checkOutput("rst exc_code", exc_code, 0);
    checkOutput("rst epc_out", epc_out, 0);
    checkOutput("rst badvaddr_wen", badvaddr_wen, 0);
    clearInputs; hw_int = 6'h0; int_mask = 6'h0;
    @(negedge clk) resetn = 1'b1;
    tick;

    for (int i = 0; i < NV; i++) begin
      applyStimulus(vecs[i]);
      #1;
      checkOutput($sformatf("v%0d wb_kill", i), wb_kill, vecs[i].kill);
      tick;
      clearInputs;
      #1;
      checkOutput($sformatf("v%0d exc_bus", i), exc_bus,
                  vecs[i].isEret ? {1'b1, vecs[i].ep} : {1'b1, ENTRY});
      checkOutput($sformatf("v%0d exc_commit", i), exc_commit, !vecs[i].isEret);
      checkOutput($sformatf("v%0d eret_commit", i), eret_commit, vecs[i].isEret);
      checkOutput($sformatf("v%0d badvaddr_wen", i), badvaddr_wen, vecs[i].bwen);
      if (!vecs[i].isEret) begin
        checkOutput($sformatf("v%0d exc_code", i), exc_code, vecs[i].code);
        checkOutput($sformatf("v%0d epc_out", i), epc_out, vecs[i].pc);
      end
      if (vecs[i].bwen)
        checkOutput($sformatf("v%0d badvaddr", i), badvaddr, vecs[i].bva);
      cancelCnt = 0; validCnt = 0;
      for (int k = 0; k < 20 && busy; k++) begin
        if (cancel) cancelCnt++;
        if (exc_bus[32]) validCnt++;
        tick; #1;
      end
      checkOutput($sformatf("v%0d idle", i), busy, 0);
      checkOutput($sformatf("v%0d cancel cycles", i), cancelCnt, 3);
      checkOutput($sformatf("v%0d redirect cycles", i), validCnt, 1);
    end

    // Interrupt: 2-edge synchronizer, waits for wb_valid, beats a simultaneous overflow.
    status_ie = 1'b1; status_exl = 1'b0; int_mask = 6'b000100; hw_int = 6'b000100;
    tick;
    checkOutput("int ip after 1 edge", ip_pending, 6'b000000);
    tick;
    checkOutput("int ip after 2 edges", ip_pending, 6'b000100);
    checkOutput("int no wb_valid no kill", wb_kill, 0);
    tick;
    checkOutput("int waits for wb_valid", busy, 0);
    wb_valid = 1'b1; exc_vec = 7'b0010000; wb_pc = 32'h80000100;
    #1;
    checkOutput("int wb_kill", wb_kill, 1);
    tick; clearInputs; #1;
    checkOutput("int exc_code", exc_code, 5'd0);
    checkOutput("int exc_commit", exc_commit, 1);
    checkOutput("int badvaddr_wen", badvaddr_wen, 0);
    checkOutput("int epc_out", epc_out, 32'h80000100);
    waitIdle("int drain");

    // EXL masks the interrupt.
    status_exl = 1'b1; wb_valid = 1'b1; wb_pc = 32'h80000200;
    #1;
    checkOutput("exl wb_kill", wb_kill, 0);
    tick; clearInputs; #1;
    checkOutput("exl no event", busy, 0);
    status_exl = 1'b0; hw_int = 6'h0; int_mask = 6'h0;
    tick; tick;

    // Causes arriving during FLUSH are ignored.
    wb_valid = 1'b1; exc_vec = 7'b0010000; wb_pc = 32'h80000300;
    tick; clearInputs;
    tick;
    wb_valid = 1'b1; exc_vec = 7'b1000000; wb_pc = 32'h80000304;
    #1;
    checkOutput("flush wb_kill a", wb_kill, 0);
    checkOutput("flush exc_bus a", exc_bus[32], 0);
    tick; #1;
    checkOutput("flush wb_kill b", wb_kill, 0);
    checkOutput("flush cancel b", cancel, 1);
    checkOutput("flush exc_bus b", exc_bus[32], 0);
    tick; clearInputs;
    checkOutput("flush back idle", busy, 0);
    tick;
    checkOutput("flush no 2nd redirect", exc_bus[32], 0);
    checkOutput("flush stays idle", busy, 0);

    // Reset during REDIRECT aborts at once.
    wb_valid = 1'b1; exc_vec = 7'b0010000; wb_pc = 32'h80000400;
    tick; clearInputs; #1;
    checkOutput("rstmid in redirect", exc_bus[32], 1);
    #1 resetn = 1'b0;
    #1;
    checkOutput("rstmid cancel", cancel, 0);
    checkOutput("rstmid exc_bus", exc_bus, 0);
    checkOutput("rstmid exc_commit", exc_commit, 0);
    @(negedge clk) resetn = 1'b1;
    tick;
    checkOutput("rstmid busy after", busy, 0);
    checkOutput("rstmid exc_bus after", exc_bus, 0);
    tick;
    checkOutput("rstmid cancel after", cancel, 0);

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
